// File: rtl/aes_pt_stream_gen.sv
// aes_pt_stream_gen
// -----------------------------------------------------------------------------
// Purpose: on-chip plaintext source feeding the pipelined AES core. After a
// start pulse it emits count_i 128-bit blocks over a valid/ready handshake,
// at up to one block per clock. Blocks come from a seeded xorshift128
// generator whose state persists across runs.
//
// Build option: define AES_PT_TVLA_EN to interleave a fixed block for TVLA
// captures (even block index -> latched fixed block, odd -> random block).
// Without it every block is random and tvla_fixed_o is tied low.
//
// Ports:
//   clk          crypto clock (only clock)
//   reset        synchronous, active-high reset
//   start_i      one-cycle run start, accepted only in IDLE
//   count_i      number of blocks for the run, sampled on start_i
//   load_seed_i  load seed_i into the generator, accepted only in IDLE
//   seed_i       generator seed {x,y,z,w}; all-zero is replaced by 128'h1
//   fixed_pt_i   fixed TVLA block, sampled on start_i
//   data_o       current plaintext block (0 when not valid)
//   valid_o      data_o valid
//   ready_i      downstream accept; transfer on valid_o && ready_i
//   tvla_fixed_o current block is the fixed block
//   busy_o       run in progress
//   done_o       one-cycle pulse at end of run
//   sent_o       blocks accepted in the current or last run
// -----------------------------------------------------------------------------
module aes_pt_stream_gen #(
   parameter int pPT_WIDTH    = 128,
   parameter int pCOUNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_i,
   input  logic [pCOUNT_WIDTH-1:0] count_i,
   input  logic                    load_seed_i,
   input  logic [127:0]            seed_i,
   input  logic [127:0]            fixed_pt_i,
   output logic [pPT_WIDTH-1:0]    data_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    tvla_fixed_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [pCOUNT_WIDTH-1:0] sent_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = pCOUNT_WIDTH'(1);

   state_t                  state, state_nxt;
   logic [127:0]            prng, prng_nxt;
   logic [pCOUNT_WIDTH-1:0] sent, sent_nxt;
   logic [pCOUNT_WIDTH-1:0] count_lat, count_nxt;
   logic [127:0]            fixed_lat, fixed_nxt;
   logic [pCOUNT_WIDTH-1:0] sent_inc;
   logic                    fixed_sel;

   // One xorshift128 step on the packed state {x,y,z,w}.
   function automatic logic [127:0] xs_step(input logic [127:0] s);
      logic [31:0] x, y, z, w, t, w_new;
      x     = s[127:96];
      y     = s[95:64];
      z     = s[63:32];
      w     = s[31:0];
      t     = x ^ (x << 11);
      w_new = w ^ (w >> 19) ^ t ^ (t >> 8);
      return {y, z, w, w_new};
   endfunction

   // xorshift128 locks up at zero, so a zero seed is replaced by 1.
   function automatic logic [127:0] seed_fix(input logic [127:0] s);
      return (s == 128'd0) ? 128'h1 : s;
   endfunction

   // The block index and sent count are cleared together and step on the
   // same handshake, so the index parity is taken straight from sent.
`ifdef AES_PT_TVLA_EN
   assign fixed_sel = ~sent[0];
`else
   logic unused_fixed;
   assign fixed_sel    = 1'b0;
   assign unused_fixed = ^fixed_lat;
`endif

   // count_i <= 2^W-1 and sent stops at count, so this never wraps.
   assign sent_inc = sent + CNT_ONE;

   always_comb begin
      state_nxt = state;
      prng_nxt  = prng;
      sent_nxt  = sent;
      count_nxt = count_lat;
      fixed_nxt = fixed_lat;
      case (state)
         IDLE: begin
            // Seed first so a simultaneous start emits the new seed.
            if (load_seed_i) prng_nxt = seed_fix(seed_i);
            if (start_i) begin
               count_nxt = count_i;
               fixed_nxt = fixed_pt_i;
               sent_nxt  = '0;
               state_nxt = (count_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (ready_i) begin
               sent_nxt = sent_inc;
               // Fixed blocks do not consume a generator step.
               if (!fixed_sel) prng_nxt = xs_step(prng);
               if (sent_inc == count_lat) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         prng  <= 128'h1;
         sent  <= '0;
      end else begin
         state <= state_nxt;
         prng  <= prng_nxt;
         sent  <= sent_nxt;
      end
   end

   // Run parameters are only read while RUN, so they need no reset.
   always_ff @(posedge clk) begin
      count_lat <= count_nxt;
      fixed_lat <= fixed_nxt;
   end

   assign valid_o      = (state == RUN);
   assign busy_o       = (state == RUN);
   assign done_o       = (state == DONE);
   assign sent_o       = sent;
   assign tvla_fixed_o = valid_o & fixed_sel;
   assign data_o       = valid_o ? pPT_WIDTH'(fixed_sel ? fixed_lat : prng)
                                 : '0;

endmodule

// File: tb/tb_aes_pt_stream_gen.sv
// Testbench for aes_pt_stream_gen: table-driven runs with known xorshift
// vectors, plus randomized backpressure runs checked against a word-level
// reference model of the generator.
module tb_aes_pt_stream_gen;

   localparam int CW = 16;
`ifdef AES_PT_TVLA_EN
   localparam bit TVLA = 1'b1;
`else
   localparam bit TVLA = 1'b0;
`endif
   localparam logic [127:0] FIX = 128'hDA39A3EE_5E6B4B0D_3255BFEF_95601890;

   logic            clk = 1'b0;
   logic            reset;
   logic            start_i;
   logic [CW-1:0]   count_i;
   logic            load_seed_i;
   logic [127:0]    seed_i;
   logic [127:0]    fixed_pt_i;
   logic [127:0]    data_o;
   logic            valid_o;
   logic            ready_i;
   logic            tvla_fixed_o;
   logic            busy_o;
   logic            done_o;
   logic [CW-1:0]   sent_o;

   int vectors    = 0;
   int miscompares = 0;
   logic [127:0] mstate;

   aes_pt_stream_gen #(.pPT_WIDTH(128), .pCOUNT_WIDTH(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .count_i      (count_i),
      .load_seed_i  (load_seed_i),
      .seed_i       (seed_i),
      .fixed_pt_i   (fixed_pt_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .tvla_fixed_o (tvla_fixed_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .sent_o       (sent_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0]       seed;
      bit                 with_start;
      int                 count;
      logic [3:0][127:0]  blk;
      logic [3:0]         tv;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [127:0] seed, input bit ws, input int c,
                               input logic [127:0] b0, input logic [127:0] b1,
                               input logic [127:0] b2, input logic [127:0] b3,
                               input logic [3:0] tv);
      vec_t v;
      v.seed = seed; v.with_start = ws; v.count = c;
      v.blk[0] = b0; v.blk[1] = b1; v.blk[2] = b2; v.blk[3] = b3;
      v.tv = tv;
      return v;
   endfunction

   // Reference xorshift128 on an array of four 32-bit words.
   function automatic logic [127:0] ref_next(input logic [127:0] s);
      logic [31:0] wd[4];
      logic [31:0] t, nw;
      for (int i = 0; i < 4; i++) wd[i] = s[127 - 32*i -: 32];
      t  = wd[0] ^ (wd[0] << 11);
      nw = wd[3] ^ (wd[3] >> 19) ^ t ^ (t >> 8);
      return {wd[1], wd[2], wd[3], nw};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Start a run of c blocks from the current generator state and check every
   // cycle against the model. inj injects a start pulse mid-run.
   task automatic model_run(input int c, input bit rnd_ready, input bit inj);
      int idx, hs, cyc;
      bit stalled, finished;
      logic [127:0] held, exp;
      start_i = 1'b1; count_i = CW'(c); ready_i = 1'b1;
      tick;
      start_i = 1'b0;
      fixed_pt_i = ~FIX;
      idx = 0; hs = 0; cyc = 0; stalled = 0; finished = 0; held = '0;
      while (!finished && cyc < 20*c + 50) begin
         if (done_o) begin
            finished = 1;
         end else begin
            chk("run_valid", valid_o, 1'b1);
            exp = (TVLA && idx % 2 == 0) ? FIX : mstate;
            chk("run_data", data_o, exp);
            chk("run_tvla", tvla_fixed_o, (TVLA && idx % 2 == 0));
            if (stalled) chk("stall_hold", data_o, held);
            start_i = inj && (cyc == 2);
            count_i = CW'(50);
            ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ready_i) begin
               if (!(TVLA && idx % 2 == 0)) mstate = ref_next(mstate);
               idx++; hs++; stalled = 0;
            end else begin
               stalled = 1; held = data_o;
            end
            tick;
            start_i = 1'b0;
            cyc++;
         end
      end
      chk("run_finished", finished, 1'b1);
      chk("run_handshakes", hs, c);
      chk("run_sent", sent_o, c);
      chk("run_busy_done", busy_o, 1'b0);
      tick;
      chk("run_done_pulse", done_o, 1'b0);
      fixed_pt_i = FIX;
      ready_i = 1'b1;
   endtask

   initial begin
      logic [127:0] s;
      reset = 1'b1; start_i = 0; count_i = '0; load_seed_i = 0;
      seed_i = '0; fixed_pt_i = FIX; ready_i = 1'b1;

`ifdef AES_PT_TVLA_EN
      tbl.push_back(mk(128'h1, 0, 4, FIX, 128'h1, FIX,
                       128'h00000000_00000000_00000001_00000001, 4'b0101));
      tbl.push_back(mk(128'h0, 1, 3, FIX, 128'h1, FIX, '0, 4'b0101));
`else
      tbl.push_back(mk(128'h1, 0, 2, 128'h1,
                       128'h00000000_00000000_00000001_00000001, '0, '0, 4'b0));
      tbl.push_back(mk(128'h1, 1, 4, 128'h1,
                       128'h00000000_00000000_00000001_00000001,
                       128'h00000000_00000001_00000001_00000001,
                       128'h00000001_00000001_00000001_00000001, 4'b0));
      tbl.push_back(mk(128'h0, 0, 1, 128'h1, '0, '0, '0, 4'b0));
      tbl.push_back(mk(128'h00000001_00000000_00000000_00000000, 1, 2,
                       128'h00000001_00000000_00000000_00000000,
                       128'h00000000_00000000_00000000_00000809, '0, '0, 4'b0));
      tbl.push_back(mk(128'h00000000_00000000_00000000_80000000, 0, 3,
                       128'h00000000_00000000_00000000_80000000,
                       128'h00000000_00000000_80000000_80001000,
                       128'h00000000_80000000_80001000_80000000, '0, 4'b0));
`endif

      tick; tick;
      // Reset values
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_tvla", tvla_fixed_o, 1'b0);
      chk("rst_sent", sent_o, '0);
      chk("rst_data", data_o, '0);
      reset = 1'b0;
      tick;

      // Table-driven runs with ready held high: exact latency and blocks.
      foreach (tbl[i]) begin
         if (!tbl[i].with_start) begin
            load_seed_i = 1'b1; seed_i = tbl[i].seed;
            tick;
            load_seed_i = 1'b0;
         end
         start_i = 1'b1; count_i = CW'(tbl[i].count); ready_i = 1'b1;
         load_seed_i = tbl[i].with_start; seed_i = tbl[i].seed;
         tick;
         start_i = 1'b0; load_seed_i = 1'b0; fixed_pt_i = ~FIX;
         for (int k = 1; k <= tbl[i].count; k++) begin
            chk("tbl_valid", valid_o, 1'b1);
            chk("tbl_busy", busy_o, 1'b1);
            chk("tbl_done_early", done_o, 1'b0);
            if (k <= 4) begin
               chk("tbl_data", data_o, tbl[i].blk[k-1]);
               chk("tbl_tvla", tvla_fixed_o, tbl[i].tv[k-1]);
            end
            tick;
         end
         chk("tbl_done", done_o, 1'b1);
         chk("tbl_valid_end", valid_o, 1'b0);
         chk("tbl_sent", sent_o, tbl[i].count);
         tick;
         chk("tbl_done_clear", done_o, 1'b0);
         chk("tbl_sent_hold", sent_o, tbl[i].count);
         fixed_pt_i = FIX;
      end

      // Randomized seeds with backpressure; the follow-on run checks that the
      // generator state carries over between runs.
      for (int r = 0; r < 2; r++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         load_seed_i = 1'b1; seed_i = s;
         tick;
         load_seed_i = 1'b0;
         mstate = (s == '0) ? 128'h1 : s;
         model_run(100, 1'b1, 1'b0);
         model_run(3, 1'b0, 1'b0);
      end

      // Zero count: no block, done next cycle, generator untouched.
      start_i = 1'b1; count_i = '0;
      tick;
      start_i = 1'b0;
      chk("zero_valid", valid_o, 1'b0);
      chk("zero_done", done_o, 1'b1);
      chk("zero_sent", sent_o, '0);
      chk("zero_busy", busy_o, 1'b0);
      tick;
      chk("zero_done_clear", done_o, 1'b0);
      chk("zero_valid2", valid_o, 1'b0);
      model_run(2, 1'b0, 1'b0);

      // start_i during RUN is ignored.
      model_run(6, 1'b1, 1'b1);

      // Reset mid-run at sent_o=5, with start and seed load in the reset cycle.
      start_i = 1'b1; count_i = CW'(10); ready_i = 1'b1;
      tick;
      start_i = 1'b0;
      for (int k = 0; k < 5; k++) tick;
      chk("mid_sent5", sent_o, 5);
      chk("mid_valid", valid_o, 1'b1);
      reset = 1'b1; start_i = 1'b1; count_i = CW'(4);
      load_seed_i = 1'b1; seed_i = 128'hDEAD_BEEF;
      tick;
      reset = 1'b0; start_i = 1'b0; load_seed_i = 1'b0;
      chk("mid_rst_valid", valid_o, 1'b0);
      chk("mid_rst_sent", sent_o, '0);
      chk("mid_rst_busy", busy_o, 1'b0);
      chk("mid_rst_data", data_o, '0);
      tick;
      chk("mid_rst_idle", valid_o, 1'b0);
      mstate = 128'h1;
      model_run(2, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
